// File: rtl/hps_fpga_key_pio.sv
// ==== hps_fpga_key_pio : debounced key PIO with edge capture and level IRQ (rev 1.0) ====
`default_nettype none

module hps_fpga_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_RISING     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_RSVD = 2'd1;
  localparam logic [1:0]       ADDR_MASK = 2'd2;
  localparam logic [1:0]       ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      read_mux;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  // Keys idle high, so the whole input path resets to ones to avoid a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '1;
      sync_out  <= '1;
    end else begin
      sync_meta <= in_port;
      sync_out  <= sync_meta;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      logic [CNT_W-1:0] count;
      logic             deb_bit;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count   <= '0;
          deb_bit <= 1'b1;
        end else if (sync_out[i] == deb_bit) begin
          count <= '0;
        end else if (count == CNT_MAX) begin
          deb_bit <= sync_out[i];
          count   <= '0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end

      assign debounced[i] = deb_bit;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced_d <= '1;
    end else begin
      debounced_d <= debounced;
    end
  end

  generate
    if (EDGE_RISING != 0) begin : g_edge_rise
      assign edge_pulse = debounced & ~debounced_d;
    end else begin : g_edge_fall
      assign edge_pulse = debounced_d & ~debounced;
    end
  endgenerate

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & write_n;
  assign clear_bits   = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && (address == ADDR_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // OR-ing the pulse in after the clear lets a same-cycle edge win over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | edge_pulse;
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA: read_mux[WIDTH-1:0] = debounced;
      ADDR_RSVD: read_mux            = '0;
      ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
      default:   read_mux            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= read_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

`default_nettype wire

// File: doc/hps_fpga_key_pio.md
HPS_FPGA_KEY_PIO -- requirements
Module: hps_fpga_key_pio

Interface
REQ-001 Parameter WIDTH, default 4, number of input bits (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable clocks required before a debounced bit changes (2..65535).
REQ-003 Parameter EDGE_RISING, default 0; 0 = capture falling edges (active-low keys), 1 = capture rising edges.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select, qualifies every access.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs (push-buttons).
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt request, active-high.

Function
REQ-013 in_port passes through a 2-flop synchronizer per bit before any other use.
REQ-014 Each bit has its own debounce counter: cleared whenever synchronized bit equals debounced bit; incremented otherwise; when the count reaches DEBOUNCE_CYCLES-1 the debounced bit takes the synchronized value and the counter clears.
REQ-015 Net effect: a synchronized level held for exactly DEBOUNCE_CYCLES clocks changes the debounced bit; any shorter glitch changes nothing.
REQ-016 Counter width is ceil(log2(DEBOUNCE_CYCLES)); the counter never wraps.
REQ-017 Edge detect: a 1-cycle edge pulse per bit when debounced bit goes 1->0 (EDGE_RISING=0) or 0->1 (EDGE_RISING=1).
REQ-018 Register map: addr 0 = debounced data (RO); addr 1 = reserved, reads 0, writes ignored; addr 2 = irq_mask[WIDTH-1:0] (RW); addr 3 = edge_capture[WIDTH-1:0] (R, write-1-to-clear).
REQ-019 A write occurs in a cycle with chipselect=1 and write_n=0; no other cycle modifies mask or capture through the bus.
REQ-020 edge_capture bit sets on its edge pulse and stays set until cleared by a write with that writedata bit =1; writedata bits =0 leave capture bits unchanged.
REQ-021 Simultaneous edge pulse and write-1-to-clear on the same bit in the same cycle: bit ends set (edge wins).
REQ-022 readdata updated every clock with the addressed register zero-extended to 32 bits when chipselect=1 and write_n=1; read latency exactly 1 cycle; readdata holds its value otherwise.
REQ-023 Reads have no side effects (capture is not cleared by reading).
REQ-024 irq = OR over bits of (edge_capture & irq_mask), driven from registers, combinational only from registered state.
REQ-025 Writing irq_mask with a bit set whose capture bit is already 1 asserts irq in the next cycle; clearing the mask deasserts it the next cycle without altering edge_capture.
REQ-026 Bits of writedata above WIDTH-1 are ignored; register bits above WIDTH-1 read as 0.

Reset
REQ-027 On reset_n=0, asynchronously: synchronizer flops and debounced data = all ones (keys idle high), debounce counters = 0, edge_capture = 0, irq_mask = 0, readdata = 0, irq = 0.
REQ-028 Reset asserted mid-debounce discards the partial count; after release no edge is generated unless the debounced value later changes.
REQ-029 in_port held low through reset release: debounced bit falls DEBOUNCE_CYCLES+2 clocks later and produces one falling-edge capture.

Verification
REQ-030 Default params, in_port[0] 1->0 held: read addr 0 after settle returns 0x0000000E; read addr 3 returns 0x00000001; irq stays 0 (mask 0).
REQ-031 Glitch: in_port[1] low for 10 clocks then high: addr 0 stays 0xF, addr 3 stays 0x0.
REQ-032 Write addr 2 = 0x1 with capture bit0 set -> irq=1 next cycle; write addr 3 = 0x1 -> capture 0, irq=0 next cycle.
REQ-033 Write addr 3 = 0x4 in the same cycle bit2 edge pulse occurs -> capture bit2 reads 1, irq follows mask.
REQ-034 Write addr 1 = 0xFFFFFFFF, then read addr 1 -> 0x00000000; read of addr 2 after writing 0xFFFFFFF5 -> 0x00000005.
REQ-035 Assert reset_n=0 while capture=0xF, mask=0xF, irq=1 -> all registers 0, irq=0 immediately, readdata=0.
